// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution frame sequencer and its counters.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int MEM_RD_LAT = 1;

    // Never returns less than 1 so that degenerate sizes still yield a legal vector width.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/conv_seq_rc_cnt.sv
// Raster row/col counter with a parallel linear address counter, so row*N+col needs no multiplier.
module conv_seq_rc_cnt
    import conv_pkg::*;
#(
    parameter int N  = 100,
    parameter int AW = clog2_min1(N * N),
    parameter int CW = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic [AW-1:0] addr_o,
    output logic          col_wrap_o,
    output logic          row_wrap_o,
    output logic          last_o
);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] addr_q, addr_d;

    assign col_wrap_o = (col_q == CW'(N - 1));
    assign row_wrap_o = (row_q == CW'(N - 1));
    assign last_o     = col_wrap_o & row_wrap_o;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clr_i) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (en_i) begin
            if (col_wrap_o) begin
                col_d = '0;
                row_d = row_wrap_o ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            addr_d = last_o ? '0 : addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/conv_seq.sv
// Frame sequencer: raster-scans pixel memory, flags complete KxK windows, drains the convolutor.
// Optional cycle counter on perf_cycles_o is enabled by defining CONV_SEQ_PERF_EN.
module conv_seq
    import conv_pkg::*;
#(
    parameter int N   = 100,
    parameter int K   = 3,
    parameter int LAT = 4,
    parameter int AW  = clog2_min1(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          stall_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          shift_o,
    output logic          win_valid_o,
    output logic          running_o,
    output logic          done_o,
    output logic [31:0]   perf_cycles_o
);

    localparam int CW  = clog2_min1(N);
    localparam int DCW = clog2_min1(LAT + 1);

    seq_state_e     state_q;
    logic [DCW-1:0] drain_cnt_q;
    logic           running_q;
    logic           done_q;
    logic           shift_q;
    logic [CW-1:0]  shift_row_q;
    logic [CW-1:0]  shift_col_q;

    logic          start_acc;
    logic          drain_last;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          last_pix;
    logic          unused_col_wrap;
    logic          unused_row_wrap;

    assign rd_en_o    = (state_q == FETCH) & ~stall_i;
    assign start_acc  = (state_q == IDLE) & start_i;
    assign drain_last = (state_q == DRAIN) & (drain_cnt_q == DCW'(LAT));

    conv_seq_rc_cnt #(
        .N  (N),
        .AW (AW),
        .CW (CW)
    ) u_rc_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_acc),
        .en_i       (rd_en_o),
        .row_o      (row),
        .col_o      (col),
        .addr_o     (rd_addr_o),
        .col_wrap_o (unused_col_wrap),
        .row_wrap_o (unused_row_wrap),
        .last_o     (last_pix)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= FETCH;
                        running_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rd_en_o && last_pix) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DCW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // Pixel returns one cycle after its read; its coordinates travel alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q     <= 1'b0;
            shift_row_q <= '0;
            shift_col_q <= '0;
        end else begin
            shift_q     <= rd_en_o;
            shift_row_q <= row;
            shift_col_q <= col;
        end
    end

    assign shift_o     = shift_q;
    assign win_valid_o = shift_q & (shift_row_q >= CW'(K - 1)) & (shift_col_q >= CW'(K - 1));
    assign running_o   = running_q;
    assign done_o      = done_q;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_cnt_q;
    logic [31:0] perf_q;
    logic [31:0] perf_inc;

    assign perf_inc = (perf_cnt_q == 32'hFFFF_FFFF) ? perf_cnt_q : perf_cnt_q + 32'd1;

    // The final DRAIN cycle is included by latching the incremented value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            if (start_acc) begin
                perf_cnt_q <= '0;
            end else if (state_q == FETCH || state_q == DRAIN) begin
                perf_cnt_q <= perf_inc;
            end
            if (drain_last) begin
                perf_q <= perf_inc;
            end
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_conv_seq.sv
// Scoreboard bench for conv_seq at N=4 (K=3 and K=1 instances), LAT=2.
module tb_conv_seq;

    localparam int N   = 4;
    localparam int K   = 3;
    localparam int LAT = 2;
    localparam int AW  = 4;
`ifdef CONV_SEQ_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stall;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic          shift;
    logic          winValid;
    logic          running;
    logic          done;
    logic [31:0]   perfCycles;

    logic          start2;
    logic          stall2;
    logic          rdEn2;
    logic [AW-1:0] rdAddr2;
    logic          shift2;
    logic          winValid2;
    logic          running2;
    logic          done2;
    logic [31:0]   perfCycles2;

    int vectors = 0;
    int miscompares = 0;

    int reads, shifts, wins, runCycles, dones, stallReads, stallShifts;
    int shifts2, wins2, dones2;
    int expAddr;
    bit sbq[$];

    always #5 clk = ~clk;

    conv_seq #(.N(N), .K(K), .LAT(LAT), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .stall_i       (stall),
        .rd_en_o       (rdEn),
        .rd_addr_o     (rdAddr),
        .shift_o       (shift),
        .win_valid_o   (winValid),
        .running_o     (running),
        .done_o        (done),
        .perf_cycles_o (perfCycles)
    );

    conv_seq #(.N(N), .K(1), .LAT(LAT), .AW(AW)) dutK1 (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start2),
        .stall_i       (stall2),
        .rd_en_o       (rdEn2),
        .rd_addr_o     (rdAddr2),
        .shift_o       (shift2),
        .win_valid_o   (winValid2),
        .running_o     (running2),
        .done_o        (done2),
        .perf_cycles_o (perfCycles2)
    );

    // Compares one observed value against its expectation and keeps the tallies.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic bit expWin(input int addr, input int k);
        return ((addr / N) >= k - 1) && ((addr % N) >= k - 1);
    endfunction

    // Reads push their window expectation; the matching shift one cycle later pops it.
    always @(negedge clk) begin
        if (rst) begin
            if (shift) begin
                shifts++;
                if (stall) stallShifts++;
                if (sbq.size() == 0) checkOutput("shiftWithoutRead", 1, 0);
                else checkOutput("winValid", {31'd0, winValid}, {31'd0, sbq.pop_front()});
            end else if (winValid) begin
                checkOutput("winWithoutShift", 1, 0);
            end
            if (winValid) wins++;
            if (rdEn) begin
                reads++;
                if (stall) stallReads++;
                checkOutput("rdAddr", 32'(rdAddr), expAddr);
                sbq.push_back(expWin(expAddr, K));
                expAddr = (expAddr + 1) % (N * N);
            end
            if (running) runCycles++;
            if (done) dones++;
            if (shift2) shifts2++;
            if (winValid2) wins2++;
            if (done2) dones2++;
        end
    end

    task automatic clearCounts();
        reads = 0; shifts = 0; wins = 0; runCycles = 0; dones = 0;
        stallReads = 0; stallShifts = 0;
        shifts2 = 0; wins2 = 0; dones2 = 0;
        expAddr = 0;
        sbq.delete();
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitAddr(input int addr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rdEn && rdAddr == AW'(addr)) found = 1'b1;
        end
        if (!found) checkOutput("waitAddrTimeout", 0, 1);
    endtask

    task automatic waitDone(input bit pokeStart);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        if (!found) checkOutput("doneTimeout", 0, 1);
        if (pokeStart) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        repeat (30) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b1; stall = 1'b0; start2 = 1'b0; stall2 = 1'b0;
        clearCounts();

        repeat (3) @(negedge clk);
        checkOutput("rstRdEn", {31'd0, rdEn}, 0);
        checkOutput("rstRdAddr", 32'(rdAddr), 0);
        checkOutput("rstShift", {31'd0, shift}, 0);
        checkOutput("rstWin", {31'd0, winValid}, 0);
        checkOutput("rstRunning", {31'd0, running}, 0);
        checkOutput("rstDone", {31'd0, done}, 0);
        checkOutput("rstPerf", perfCycles, 0);
        @(posedge clk);
        #1 start = 1'b0; rst = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idleRunning", {31'd0, running}, 0);
        checkOutput("idleReads", reads, 0);

        $display("[TB] basic frame");
        clearCounts();
        applyStimulus();
        waitDone(1'b0);
        checkOutput("basicReads", reads, 16);
        checkOutput("basicShifts", shifts, 16);
        checkOutput("basicWins", wins, 4);
        checkOutput("basicRunCycles", runCycles, 19);
        checkOutput("basicDones", dones, 1);
        checkOutput("basicSbEmpty", sbq.size(), 0);
        checkOutput("basicPerf", perfCycles, PERF_ON ? 32'd19 : 32'd0);

        $display("[TB] stall after address 5");
        clearCounts();
        applyStimulus();
        waitAddr(5);
        @(posedge clk);
        #1 stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
        waitDone(1'b0);
        checkOutput("stallReadsDuring", stallReads, 0);
        checkOutput("stallShiftsDuring", stallShifts, 1);
        checkOutput("stallReads", reads, 16);
        checkOutput("stallRunCycles", runCycles, 22);
        checkOutput("stallDones", dones, 1);
        checkOutput("stallPerf", perfCycles, PERF_ON ? 32'd22 : 32'd0);

        $display("[TB] start while busy");
        clearCounts();
        applyStimulus();
        waitAddr(8);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(1'b1);
        checkOutput("busyReads", reads, 16);
        checkOutput("busyDones", dones, 1);
        checkOutput("busyRunCycles", runCycles, 19);

        $display("[TB] mid-frame reset");
        clearCounts();
        applyStimulus();
        waitAddr(7);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("asyncRdEn", {31'd0, rdEn}, 0);
        checkOutput("asyncRdAddr", 32'(rdAddr), 0);
        checkOutput("asyncShift", {31'd0, shift}, 0);
        checkOutput("asyncRunning", {31'd0, running}, 0);
        checkOutput("asyncDone", {31'd0, done}, 0);
        checkOutput("asyncPerf", perfCycles, 0);
        clearCounts();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("abandonDones", dones, 0);
        checkOutput("abandonReads", reads, 0);
        clearCounts();
        applyStimulus();
        waitDone(1'b0);
        checkOutput("restartReads", reads, 16);
        checkOutput("restartDones", dones, 1);
        checkOutput("restartRunCycles", runCycles, 19);

        $display("[TB] K=1 instance");
        clearCounts();
        @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int i = 0; i < 300 && dones2 == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("k1Dones", dones2, 1);
        checkOutput("k1Shifts", shifts2, 16);
        checkOutput("k1Wins", wins2, 16);
        checkOutput("k1Perf", perfCycles2, PERF_ON ? 32'd19 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_seq.md
# conv_seq

Frame sequencer for the convolution datapath. On a start pulse it raster-scans an N×N image: it issues one pixel-memory read per cycle, pushes each returned pixel into the line-buffer/window stage, and flags the cycles on which a complete K×K window is present. It also drains the datapath pipeline and reports frame progress through `running_o` and `done_o`. It sits between the pixel memory and the convolutor inside `conv_top`.

## Interface
- `N`, 100, image width and height in pixels; must satisfy N ≥ K.
- `K`, 3, kernel size; must satisfy 1 ≤ K ≤ N.
- `LAT`, 4, convolutor pipeline latency in cycles, from window-valid to result-valid.
- `AW`, `$clog2(N*N)`, pixel address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start_i` in 1: begin frame; sampled in IDLE only.
- `stall_i` in 1: back-pressure; blocks new reads while high.
- `rd_en_o` out 1: pixel-memory read strobe. Memory read latency is fixed at 1 cycle.
- `rd_addr_o` out AW: raster address, row*N + col.
- `shift_o` out 1: returned pixel valid; push it into the window.
- `win_valid_o` out 1: the window completed by this shift is valid.
- `running_o` out 1: frame in progress.
- `done_o` out 1: one-cycle end-of-frame pulse.
- `perf_cycles_o` out 32: cycle count of the last frame (see Configuration).

## Operation
- States and transitions:
  - IDLE → FETCH when `start_i` = 1.
  - FETCH → DRAIN after the read of address N*N−1 is issued.
  - DRAIN → DONE after LAT+1 cycles.
  - DONE → IDLE unconditionally.
- `rd_en_o` = (state == FETCH) & ~`stall_i`. This output is combinational.
- Row/col counters advance only on `rd_en_o`. Col wraps at N−1 and increments row. Row wraps at N−1, which ends FETCH.
- `rd_addr_o` is driven from a separate registered counter so that no multiplier is needed. It equals row*N + col.
- `shift_o` is `rd_en_o` delayed by one register.
- The row/col of each read is delayed together with `shift_o`.
- `win_valid_o` = `shift_o` & (row_d ≥ K−1) & (col_d ≥ K−1). This gives (N−K+1)² windows per frame, which is 9604 for the defaults.
- `running_o` is high in FETCH and DRAIN and low in IDLE and DONE.
- `done_o` is high only in DONE.
- `start_i` in any state other than IDLE is ignored. It is not queued.
- Stall boundary: a read issued in the cycle before `stall_i` rises still produces its `shift_o` one cycle later. Downstream must absorb that one in-flight pixel.
- `stall_i` has no effect in DRAIN.
- Reset asserted mid-frame:
  - All state and counters clear immediately and asynchronously.
  - No `done_o` is produced.
  - The frame is abandoned.
- Reset value of every output is 0, including `rd_addr_o` and `perf_cycles_o`.

## Timing
- Start accepted at edge E.
- With no stalls:
  - `rd_en_o` is high for N*N consecutive cycles starting at E, with addresses 0…N*N−1.
  - `shift_o` is high during cycles E+1…E+N*N.
  - DRAIN occupies LAT+1 cycles.
  - `done_o` is high on the cycle after the last DRAIN cycle.
- `running_o` is high for N*N + LAT + 1 cycles plus the number of stall cycles that occur in FETCH.
- The last `win_valid_o` is followed by its convolutor result exactly LAT cycles later, which is before `running_o` falls.
- If `start_i` is held high, frames run back to back with a gap of DONE plus one IDLE cycle.

## Configuration
- `CONV_SEQ_PERF_EN` defined:
  - A 32-bit counter clears on start accept and counts every FETCH and DRAIN cycle, saturating at 2³²−1.
  - The value is latched into `perf_cycles_o` on entry to DONE and held until the next frame's DONE.
- `CONV_SEQ_PERF_EN` not defined:
  - The counter is absent.
  - `perf_cycles_o` is tied to 0.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - the 1-cycle memory latency constant;
  - the clog2 helper.
- One sub-module, `conv_seq_rc_cnt`: row/col/address counter with enable, wrap flags and a last-pixel flag. It is reused later for output-address generation.

## Test plan
- Reset: hold `rst` = 0 with `start_i` = 1 → all outputs 0 and no reads. After release with `start_i` = 0 → IDLE persists.
- Basic frame, N=4, K=3, LAT=2, one start pulse, no stalls:
  - `rd_addr_o` = 0…15 on consecutive cycles.
  - `win_valid_o` is high on exactly the shifts of addresses 10, 11, 14 and 15.
  - `running_o` is high for 19 cycles.
  - `done_o` pulses once.
- Stall: `stall_i` high for 3 cycles after the read of address 5:
  - `rd_en_o` is low for those 3 cycles and the next read is address 6.
  - Exactly one `shift_o` occurs during the stall.
  - 16 reads in total; `running_o` is high for 22 cycles.
- Start while busy: pulse `start_i` mid-FETCH and again in DONE → ignored; exactly one frame occurs and one `done_o`.
- Mid-frame reset: assert `rst` low after the read of address 7 → outputs go to 0 without waiting for a clock edge. No `done_o` follows. The next start restarts at address 0.
- K=1, N=4 → `win_valid_o` accompanies every one of the 16 shifts. With `CONV_SEQ_PERF_EN` defined and LAT=2, `perf_cycles_o` = 19 after DONE.
